// File: rtl/tx_frame_fcs_append.sv
// Frame formatter for the RMII TX FIFO: zero-pads short frames, truncates
// long ones, appends the CRC-32 FCS and flags end-of-data on the last byte.
module tx_frame_fcs_append #(
  parameter int unsigned MIN_LEN     = 60,
  parameter int unsigned MAX_LEN     = 1514,
  parameter bit          BIT_REVERSE = 1'b1
) (
  input  logic        REF_CLK,
  input  logic        arst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        fifo_afull,
  output logic        fifo_wren,
  output logic [7:0]  fifo_din,
  output logic        fifo_EOD_in,
  output logic [15:0] frame_count,
  output logic [15:0] pad_count,
  output logic [15:0] oversize_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAD,
    S_FCS
  } state_t;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [10:0] MIN_C    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_C    = 11'(MAX_LEN);

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] out_byte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = BIT_REVERSE ? b[7-i] : b[i];
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [10:0] cnt_q, cnt_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic        over_q, over_d;
  logic        wren_q, wren_d;
  logic [7:0]  din_q, din_d;
  logic        eod_q, eod_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] pad_q, pad_d;
  logic [15:0] ovc_q, ovc_d;

  logic        xfer;
  logic [10:0] cnt_inc;
  logic [10:0] cnt_nx;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;

  assign in_ready = arst_n & ~fifo_afull &
                    (state_q == S_IDLE | state_q == S_DATA);
  assign xfer     = in_valid & in_ready;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 11'd1;
  assign fcs      = ~crc_q;
  assign fcs_byte = fcs[{fcs_idx_q, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    cnt_nx    = cnt_q;
    fcs_idx_d = fcs_idx_q;
    over_d    = over_q;
    wren_d    = 1'b0;
    din_d     = din_q;
    eod_d     = 1'b0;
    frame_d   = frame_q;
    pad_d     = pad_q;
    ovc_d     = ovc_q;
    unique case (state_q)
      S_IDLE: begin
        crc_d     = CRC_INIT;
        cnt_d     = '0;
        fcs_idx_d = '0;
        over_d    = 1'b0;
        if (xfer) begin
          wren_d  = 1'b1;
          din_d   = out_byte(in_data);
          crc_d   = crc_byte(CRC_INIT, in_data);
          cnt_d   = 11'd1;
          state_d = S_DATA;
          if (in_last) begin
            state_d = (11'd1 < MIN_C) ? S_PAD : S_FCS;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (cnt_q < MAX_C) begin
            wren_d = 1'b1;
            din_d  = out_byte(in_data);
            crc_d  = crc_byte(crc_q, in_data);
            cnt_d  = cnt_inc;
            cnt_nx = cnt_inc;
          end else begin
            over_d = 1'b1;
          end
          if (in_last) begin
            state_d = (cnt_nx < MIN_C) ? S_PAD : S_FCS;
          end
        end
      end
      S_PAD: begin
        if (!fifo_afull) begin
          wren_d = 1'b1;
          din_d  = out_byte(8'h00);
          crc_d  = crc_byte(crc_q, 8'h00);
          cnt_d  = cnt_inc;
          if (cnt_inc >= MIN_C) begin
            state_d = S_FCS;
            pad_d   = pad_q + 16'd1;
          end
        end
      end
      S_FCS: begin
        if (!fifo_afull) begin
          wren_d    = 1'b1;
          din_d     = out_byte(fcs_byte);
          fcs_idx_d = fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            eod_d   = 1'b1;
            frame_d = frame_q + 16'd1;
            if (over_q) ovc_d = ovc_q + 16'd1;
            over_d  = 1'b0;
            crc_d   = CRC_INIT;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge REF_CLK) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      crc_q     <= CRC_INIT;
      cnt_q     <= '0;
      fcs_idx_q <= '0;
      over_q    <= 1'b0;
      wren_q    <= 1'b0;
      din_q     <= '0;
      eod_q     <= 1'b0;
      frame_q   <= '0;
      pad_q     <= '0;
      ovc_q     <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      fcs_idx_q <= fcs_idx_d;
      over_q    <= over_d;
      wren_q    <= wren_d;
      din_q     <= din_d;
      eod_q     <= eod_d;
      frame_q   <= frame_d;
      pad_q     <= pad_d;
      ovc_q     <= ovc_d;
    end
  end

  assign fifo_wren      = wren_q;
  assign fifo_din       = din_q;
  assign fifo_EOD_in    = eod_q;
  assign frame_count    = frame_q;
  assign pad_count      = pad_q;
  assign oversize_count = ovc_q;

endmodule
